// File: rtl/gelato_fetch_scheduler.sv
// Per-warp PC table with a round-robin fetch scheduler. Presents one READY
// warp's PC to the instruction fetch unit and keeps at most one fetch per warp in flight.
module gelato_fetch_scheduler #(
  parameter int NUM_WARPS = 32,
  parameter int WARP_W    = $clog2(NUM_WARPS),
  parameter int PC_W      = 32,
  parameter int SPLIT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 launch_valid,
  input  logic [WARP_W-1:0]    launch_warp,
  input  logic [PC_W-1:0]      launch_pc,
  input  logic [SPLIT_W-1:0]   launch_split,
  input  logic                 update_valid,
  input  logic [WARP_W-1:0]    update_warp,
  input  logic [PC_W-1:0]      update_pc,
  input  logic                 finish_valid,
  input  logic [WARP_W-1:0]    finish_warp,
  output logic                 fetch_valid,
  input  logic                 fetch_ready,
  output logic [PC_W-1:0]      fetch_pc,
  output logic [WARP_W-1:0]    fetch_warp_num,
  output logic [SPLIT_W-1:0]   fetch_split_table_num,
  output logic [NUM_WARPS-1:0] warp_active
);

  localparam logic [1:0] ST_INACTIVE = 2'd0;
  localparam logic [1:0] ST_READY    = 2'd1;
  localparam logic [1:0] ST_INFLIGHT = 2'd2;

  logic [1:0]         warp_state [NUM_WARPS];
  logic [PC_W-1:0]    warp_pc    [NUM_WARPS];
  logic [SPLIT_W-1:0] warp_split [NUM_WARPS];
  logic [WARP_W-1:0]  rr_ptr;

  logic              accept;
  logic              load;
  logic              finish_presented;
  logic              grant_found;
  logic [WARP_W-1:0] grant_warp;
  logic [WARP_W-1:0] cand;

  assign accept           = rdy & fetch_valid & fetch_ready;
  assign load             = ~fetch_valid | accept;
  assign finish_presented = fetch_valid & finish_valid & (finish_warp == fetch_warp_num);

  // Round-robin search starting just after the last grant. A warp being
  // accepted or retired this cycle is skipped so it is never re-presented.
  // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_warp  = '0;
    cand        = '0;
    for (int off = 1; off <= NUM_WARPS; off++) begin
      cand = rr_ptr + WARP_W'(off);
      if (!grant_found && warp_state[cand] == ST_READY &&
          !(accept && cand == fetch_warp_num) &&
          !(finish_valid && cand == finish_warp)) begin
        grant_found = 1'b1;
        grant_warp  = cand;
      end
    end
  end

  // Same-warp precedence: finish > update > launch; accept only touches READY warps.
  // NOTE: the PC/split table is cleared on reset so a relaunch-free warp never exposes stale values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        warp_state[i] <= ST_INACTIVE;
        warp_pc[i]    <= '0;
        warp_split[i] <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (finish_valid && finish_warp == WARP_W'(i)) begin
          warp_state[i] <= ST_INACTIVE;
        end else if (update_valid && update_warp == WARP_W'(i) &&
                     warp_state[i] == ST_INFLIGHT) begin
          warp_state[i] <= ST_READY;
          warp_pc[i]    <= update_pc;
        end else if (launch_valid && launch_warp == WARP_W'(i) &&
                     warp_state[i] == ST_INACTIVE) begin
          warp_state[i] <= ST_READY;
          warp_pc[i]    <= launch_pc;
          warp_split[i] <= launch_split;
        end else if (accept && fetch_warp_num == WARP_W'(i) &&
                     warp_state[i] == ST_READY) begin
          warp_state[i] <= ST_INFLIGHT;
        end
      end
    end
  end

  // Request register: reloads only when empty or being accepted, so fields
  // stay stable under backpressure; a retire of the presented warp withdraws it.
  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid           <= 1'b0;
      fetch_pc              <= '0;
      fetch_warp_num        <= '0;
      fetch_split_table_num <= '0;
      rr_ptr                <= WARP_W'(NUM_WARPS - 1);
    end else if (rdy) begin
      if (load) begin
        fetch_valid <= grant_found;
        if (grant_found) begin
          fetch_pc              <= warp_pc[grant_warp];
          fetch_warp_num        <= grant_warp;
          fetch_split_table_num <= warp_split[grant_warp];
          rr_ptr                <= grant_warp;
        end
      end else if (finish_presented) begin
        fetch_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    warp_active = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      warp_active[i] = (warp_state[i] != ST_INACTIVE);
    end
  end

endmodule
